// File: rtl/ula16_pkg.sv
// Shared definitions for the 16-bit sequencer and its 8-bit ALU slice:
// opcodes, sequencer state encoding and the fix-up increment constant.
package ula16_pkg;

   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [7:0] FIX_ONE = 8'h01;

endpackage

// File: rtl/ula.sv
// 8-bit combinational ALU slice. o_carry is the ADD carry-out; for SUB it
// carries the borrow, which the sequencer does not rely on.
module ula
   import ula16_pkg::*;
(
   input  logic [3:0] i_op,
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   output logic [7:0] o_y,
   output logic       o_carry
);

   logic [8:0] w_sum;
   logic [8:0] w_diff;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   always_comb begin
      o_y     = 8'h00;
      o_carry = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_y     = w_sum[7:0];
            o_carry = w_sum[8];
         end
         OP_SUB: begin
            o_y     = w_diff[7:0];
            o_carry = w_diff[8];
         end
         OP_AND:  o_y = i_a & i_b;
         OP_OR:   o_y = i_a | i_b;
         OP_NOT:  o_y = ~i_b;
         OP_XOR:  o_y = i_a ^ i_b;
         default: o_y = 8'h00;
      endcase
   end

endmodule

// File: rtl/ula16_seq.sv
// 16-bit operation sequencer over one 8-bit ula: low pass, high pass, optional
// carry/borrow fix-up pass. Optional zero flag under ULA16_SEQ_ZERO_FLAG_EN.
// Handshake: start is accepted only while busy=0; done pulses one cycle on the
// same edge that loads result/carry; start is ignored for the whole busy window.
module ula16_seq
   import ula16_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        carry,
`ifdef ULA16_SEQ_ZERO_FLAG_EN
   output logic        zero,
`endif
   output logic [2:0]  dbg_state
);

   state_t      r_state;
   logic [3:0]  r_op;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [7:0]  r_lo;
   logic [7:0]  r_hi;
   logic        r_c0;
   logic        r_c1;
   logic        r_bw0;
   logic        r_bw1;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_result;
   logic        r_carry;
`ifdef ULA16_SEQ_ZERO_FLAG_EN
   logic        r_zero;
`endif

   logic [7:0]  w_alu_a;
   logic [7:0]  w_alu_b;
   logic [7:0]  w_alu_y;
   logic        w_alu_c;
   logic        w_is_add;
   logic        w_is_sub;
   logic        w_bw0;
   logic        w_bw1;
   logic        w_fix;
   logic [15:0] w_res;

   assign w_is_add = (r_op == OP_ADD);
   assign w_is_sub = (r_op == OP_SUB);
   // Borrows are derived from the latched operands; the ALU carry is only trusted for ADD.
   assign w_bw0    = (r_a[7:0] < r_b[7:0]);
   assign w_bw1    = (r_a[15:8] < r_b[15:8]) | ((r_a[15:8] == r_b[15:8]) & r_bw0);
   assign w_fix    = (w_is_add & r_c0) | (w_is_sub & r_bw0);
   assign w_res    = {w_alu_y, r_lo};

   always_comb begin
      w_alu_a = r_a[7:0];
      w_alu_b = r_b[7:0];
      case (r_state)
         HI: begin
            w_alu_a = r_a[15:8];
            w_alu_b = r_b[15:8];
         end
         FIX: begin
            w_alu_a = r_hi;
            w_alu_b = FIX_ONE;
         end
         default: begin
            w_alu_a = r_a[7:0];
            w_alu_b = r_b[7:0];
         end
      endcase
   end

   ula u_ula (
      .i_op    (r_op),
      .i_a     (w_alu_a),
      .i_b     (w_alu_b),
      .o_y     (w_alu_y),
      .o_carry (w_alu_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_op     <= 4'h0;
         r_a      <= 16'h0000;
         r_b      <= 16'h0000;
         r_lo     <= 8'h00;
         r_hi     <= 8'h00;
         r_c0     <= 1'b0;
         r_c1     <= 1'b0;
         r_bw0    <= 1'b0;
         r_bw1    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= 16'h0000;
         r_carry  <= 1'b0;
`ifdef ULA16_SEQ_ZERO_FLAG_EN
         r_zero   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op    <= op;
                  r_a     <= a;
                  r_b     <= b;
                  r_c0    <= 1'b0;
                  r_c1    <= 1'b0;
                  r_bw0   <= 1'b0;
                  r_bw1   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= LO;
               end
            end
            LO: begin
               r_lo    <= w_alu_y;
               r_c0    <= w_is_add & w_alu_c;
               r_bw0   <= w_is_sub & w_bw0;
               r_state <= HI;
            end
            HI: begin
               r_hi  <= w_alu_y;
               r_c1  <= w_is_add & w_alu_c;
               r_bw1 <= w_is_sub & w_bw1;
               if (w_fix) begin
                  r_state <= FIX;
               end else begin
                  // Completion is registered on the edge entering DONE so done and result align.
                  r_result <= w_res;
                  r_carry  <= (w_is_add & w_alu_c) | (w_is_sub & w_bw1);
`ifdef ULA16_SEQ_ZERO_FLAG_EN
                  r_zero   <= (w_res == 16'h0000);
`endif
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            FIX: begin
               r_hi     <= w_alu_y;
               r_result <= w_res;
               r_carry  <= (w_is_add & (r_c1 | w_alu_c)) | (w_is_sub & r_bw1);
`ifdef ULA16_SEQ_ZERO_FLAG_EN
               r_zero   <= (w_res == 16'h0000);
`endif
               r_done   <= 1'b1;
               r_state  <= DONE;
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign carry     = r_carry;
   assign dbg_state = r_state;
`ifdef ULA16_SEQ_ZERO_FLAG_EN
   assign zero      = r_zero;
`endif

endmodule

// File: tb/tb_ula16_seq.sv
// Directed bench for ula16_seq: arithmetic/logic vectors with hand-computed
// results, latency, start-ignore while busy and mid-operation reset.
module tb_ula16_seq;
   import ula16_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry;
`ifdef ULA16_SEQ_ZERO_FLAG_EN
   logic        zero;
`endif
   logic [2:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   ula16_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry     (carry),
`ifdef ULA16_SEQ_ZERO_FLAG_EN
      .zero      (zero),
`endif
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one operation from a negedge, scrambles inputs after accept, and
   // checks latency, result, carry and the return to idle.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] er, input logic ec,
                         input int el);
      int lat;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 4'($urandom_range(0, 15));
      a     = 16'($urandom_range(0, 65535));
      b     = 16'($urandom_range(0, 65535));
      @(negedge clk);
      chk($sformatf("%s_busy", tag), busy, 1);
      lat = 1;
      while (!done && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("%s_lat", tag), lat, el);
      chk($sformatf("%s_res", tag), result, er);
      chk($sformatf("%s_carry", tag), carry, ec);
`ifdef ULA16_SEQ_ZERO_FLAG_EN
      chk($sformatf("%s_zero", tag), zero, (er == 16'h0000));
`endif
      @(negedge clk);
      chk($sformatf("%s_idle_done", tag), done, 0);
      chk($sformatf("%s_idle_busy", tag), busy, 0);
   endtask

   initial begin
      int n_done;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 4'h0;
      a     = 16'h0000;
      b     = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 16'h0000);
      chk("rst_carry", carry, 0);
      chk("rst_state", dbg_state, IDLE);
`ifdef ULA16_SEQ_ZERO_FLAG_EN
      chk("rst_zero", zero, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      run_op("add_00ff_1", OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 4);
      run_op("add_ffff_1", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4);
      run_op("add_8000_8000", OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 3);
      run_op("sub_0100_1", OP_SUB, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 4);
      run_op("sub_0000_1", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 4);
      run_op("xor", OP_XOR, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 3);
      run_op("not", OP_NOT, 16'h5555, 16'h1234, 16'hEDCB, 1'b0, 3);
      run_op("and", OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 3);
      run_op("or", OP_OR, 16'h1200, 16'h0034, 16'h1234, 1'b0, 3);
      run_op("add_ffff_ffff", OP_ADD, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 4);
      run_op("inv_op0", 4'h0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 3);
      run_op("sub_1234_1234", OP_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3);
      run_op("add_1_1", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 3);
      run_op("sub_1200_00ff", OP_SUB, 16'h1200, 16'h00FF, 16'h1101, 1'b0, 4);
      run_op("inv_opf", 4'hF, 16'h1234, 16'h5678, 16'h0000, 1'b0, 3);

      // start pulses during LO, HI and DONE must not disturb the first operation
      start = 1'b1;
      op    = OP_ADD;
      a     = 16'h00FF;
      b     = 16'h0001;
      @(posedge clk);
      #1;
      chk("ign_busy_lo", busy, 1);
      op = OP_SUB;
      a  = 16'h1111;
      b  = 16'h2222;
      @(posedge clk);
      #1;
      chk("ign_state_hi", dbg_state, HI);
      op = OP_XOR;
      a  = 16'hFFFF;
      b  = 16'h0000;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("ign_done", done, 1);
      chk("ign_res", result, 16'h0100);
      chk("ign_carry", carry, 0);
      start = 1'b1;
      op    = OP_OR;
      a     = 16'h0F0F;
      b     = 16'hF0F0;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ign_busy_after", busy, 0);
      chk("ign_done_after", done, 0);
      n_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("ign_no_extra_done", n_done, 0);
      chk("ign_res_hold", result, 16'h0100);

      // reset during HI aborts the operation and clears the previous result
      start = 1'b1;
      op    = OP_ADD;
      a     = 16'h1234;
      b     = 16'h1111;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("rmid_state_hi", dbg_state, HI);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rmid_busy", busy, 0);
      chk("rmid_done", done, 0);
      chk("rmid_res", result, 16'h0000);
      chk("rmid_carry", carry, 0);
      n_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("rmid_no_done", n_done, 0);

      run_op("post_rst_add", OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
